lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store unit between the ALU/register file and the word-wide data memory (32 x 32-bit, one write enable, combinational read, write on clk rising edge).
- Converts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses.
- Sub-word stores use a two-step read-modify-write.
- Sub-word loads are extracted and sign- or zero-extended before they reach register-file write data.

Parameters:
- ADDR_W, 5, word-index width of the data memory. The byte address uses bits [ADDR_W+1:0]; higher bits are ignored, so addresses wrap silently.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  request valid; sampled only while ready=1
- store  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 half, 10 word, 11 reserved
- uns  in  1  zero-extend a load (LBU/LHU) when 1
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (register rd2), right-aligned
- ready  out  1  unit idle, can accept a request
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; request rejected
- rdata  out  32  load result, valid from done onward until the next accept
- dm_address  out  ADDR_W  word index to the data memory
- dm_wd  out  32  data-memory write data
- dm_we  out  1  data-memory write enable
- dm_rd  in  32  data-memory read data (combinational)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rdata=0, done=0, err=0, dm_we=0, dm_wd=0, dm_address=0, ready=1.
  - Reset mid-operation aborts immediately. dm_we drops asynchronously, so no partial write occurs after reset asserts.
- States: IDLE, ACCESS, MERGE, RESP.
  - dm_we is decoded from state only. dm_address comes from the latched address in all non-IDLE states.
- IDLE: ready=1.
  - On req=1 at a clk edge, latch store/size/uns/addr/wdata.
  - Malformed request (size=11, half with addr[0]=1, or word with addr[1:0]!=0): go to RESP with err=1 and no memory access.
  - Otherwise go to ACCESS.
- ACCESS:
  - Load: rdata <= extracted lane of dm_rd, using byte lane addr[1:0] or half lane addr[1]. Extend per uns. Go to RESP.
  - Store word: dm_we=1, dm_wd=wdata. Go to RESP.
  - Store byte/half: merge register <= dm_rd with the selected lane replaced by wdata[7:0] or wdata[15:0]. Go to MERGE.
- MERGE: dm_we=1, dm_wd=merge register; other lanes are unchanged. Go to RESP.
- RESP: done=1 and err as latched for exactly one cycle, then go to IDLE.
- Latency from accept edge to done cycle:
  - Loads and SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Errors: 1 cycle.
- Endianness: little-endian. Byte 0 is bits [7:0].
- req while ready=0 is ignored, not queued. The core stalls on ready/done.
- rdata holds its last value through stores and errors.
- A back-to-back req in the cycle after done is accepted (IDLE is re-entered after RESP).

Optional Feature:
- LSU_ERR_EN.
- Defined: misalignment and size=11 are detected as above and reported with err.
- Undefined: err is tied to 0.
  - Misaligned halves ignore addr[0]; misaligned words ignore addr[1:0] (force-aligned).
  - size=11 is treated as word.
  - All requests reach ACCESS.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - the state enum;
  - the LANE_BYTE=8 and LANE_HALF=16 constants.
- Sub-module lsu_align, purely combinational: load extract/extend and store lane merge.
- FSM and registers stay in lsu_ctrl.

Test Plan:
- Word round trip: SW 0x11223344 @0x14, then LW @0x14 -> dm_we for one cycle at word index 5; LW rdata=0x11223344; done 2 cycles after each accept.
- Byte store RMW: word 5=0x11223344, SB 0xAA @0x15 -> word 5=0x1122AA44; dm_we asserted only in MERGE; done 3 cycles after accept.
- Sign/zero extend: word 5=0x8000FF7F:
  - LB @0x16 -> 0x00000000
  - LB @0x15 -> 0xFFFFFFFF
  - LBU @0x15 -> 0x000000FF
  - LH @0x16 -> 0xFFFF8000
  - LHU @0x16 -> 0x00008000
- Misaligned, LSU_ERR_EN defined: LW @0x13 -> done with err=1 one cycle after accept, no dm_we, rdata unchanged. Without the macro: reads word 4, err=0.
- Reset mid-store: assert rst_n=0 during MERGE -> dm_we=0 immediately, word unchanged, ready=1 and done=0 after release.
- Busy ignore and wrap: req pulsed during ACCESS is ignored. SW @0x94 (bit 7 set) writes word index 5.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, states and request checks for the load/store unit
// Contents: size encodings, lane widths, FSM state type, malformed-request check.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int LANE_BYTE = 8;
  localparam int LANE_HALF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Reserved size, odd half address or unaligned word address.
  function automatic logic malformed(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == SZ_RSVD) ||
           ((size == SZ_HALF) && addr_lo[0]) ||
           ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational load lane extract/extend and store lane merge
// Ports:
//   size      in  2   access size (byte/half/word)
//   uns       in  1   zero-extend loads when 1
//   addr_lo   in  2   byte offset within the word
//   rd        in  32  memory word read data
//   wdata     in  16  low half of the store data (only sub-word stores merge)
//   load_val  out 32  extracted and extended load result
//   merge_val out 32  rd with the addressed lane replaced by store data
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rd,
  input  logic [15:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merge_val
);

  logic [LANE_BYTE-1:0] byte_lane;
  logic [LANE_HALF-1:0] half_lane;

  always_comb begin
    byte_lane = rd[{addr_lo, 3'b000} +: LANE_BYTE];
    half_lane = rd[{addr_lo[1], 4'b0000} +: LANE_HALF];
    load_val  = rd;
    merge_val = rd;
    case (size)
      SZ_BYTE: begin
        load_val = uns ? {{(32-LANE_BYTE){1'b0}}, byte_lane}
                       : {{(32-LANE_BYTE){byte_lane[LANE_BYTE-1]}}, byte_lane};
        merge_val[{addr_lo, 3'b000} +: LANE_BYTE] = wdata[LANE_BYTE-1:0];
      end
      SZ_HALF: begin
        // addr_lo[0] is ignored here, which also gives force-alignment
        // when error reporting is compiled out.
        load_val = uns ? {{(32-LANE_HALF){1'b0}}, half_lane}
                       : {{(32-LANE_HALF){half_lane[LANE_HALF-1]}}, half_lane};
        merge_val[{addr_lo[1], 4'b0000} +: LANE_HALF] = wdata;
      end
      default: begin
        load_val  = rd;
        merge_val = rd;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - byte-addressed load/store unit in front of a word-wide data memory
// Optional feature macro: LSU_ERR_EN (report malformed requests with err; otherwise
// force-align them, treat size 11 as word and keep err low).
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req/store/size/uns     request valid (sampled while ready), store/load, size, zero-extend
//   addr/wdata             byte address, right-aligned store data
//   ready/done/err/rdata   idle, completion pulse, reject flag with done, load result
//   dm_address/dm_wd/dm_we data-memory word index, write data, write enable
//   dm_rd                  combinational data-memory read data
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              store,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] dm_address,
  output logic [31:0]       dm_wd,
  output logic              dm_we,
  input  logic [31:0]       dm_rd
);

  state_t            state;
  logic              store_q;
  logic              uns_q;
  logic              err_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic [31:0]       rdata_q;

  logic [31:0] load_val;
  logic [31:0] merge_val;
  logic [1:0]  size_in;
  logic        bad_in;
  logic        store_word;

  // Byte address bits above the memory range wrap silently.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

`ifdef LSU_ERR_EN
  assign size_in = size;
  assign bad_in  = malformed(size, addr[1:0]);
`else
  assign size_in = (size == SZ_RSVD) ? SZ_WORD : size;
  assign bad_in  = 1'b0;
`endif

  lsu_align u_align (
    .size      (size_q),
    .uns       (uns_q),
    .addr_lo   (addr_q[1:0]),
    .rd        (dm_rd),
    .wdata     (wdata_q[15:0]),
    .load_val  (load_val),
    .merge_val (merge_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      store_q <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            store_q <= store;
            uns_q   <= uns;
            size_q  <= size_in;
            addr_q  <= addr[ADDR_W+1:0];
            wdata_q <= wdata;
            err_q   <= bad_in;
            state   <= bad_in ? ST_RESP : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!store_q) begin
            rdata_q <= load_val;
            state   <= ST_RESP;
          end else if (size_q == SZ_WORD) begin
            state <= ST_RESP;
          end else begin
            // Sub-word store: capture the merged word, write it next cycle.
            merge_q <= merge_val;
            state   <= ST_MERGE;
          end
        end
        ST_MERGE: state <= ST_RESP;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode from state so an asynchronous reset drops dm_we at once.
  assign store_word = (state == ST_ACCESS) && store_q && (size_q == SZ_WORD);
  assign ready      = (state == ST_IDLE);
  assign done       = (state == ST_RESP);
  assign err        = done & err_q;
  assign dm_we      = store_word || (state == ST_MERGE);
  assign dm_wd      = (state == ST_MERGE) ? merge_q : (store_word ? wdata_q : '0);
  assign dm_address = ready ? '0 : addr_q[ADDR_W+1:2];
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl with a byte-array reference model
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        store = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, done, err, dm_we;
  logic [31:0] rdata, dm_wd, dm_rd;
  logic [4:0]  dm_address;

  lsu_ctrl #(.ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .store(store), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err), .rdata(rdata),
    .dm_address(dm_address), .dm_wd(dm_wd), .dm_we(dm_we), .dm_rd(dm_rd)
  );

  always #5 clk = ~clk;

  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] x;
    x = 32'(i + 1);
    return (32'h9E3779B9 * x) ^ 32'h5A5A0F0F;
  endfunction

  // Data memory: combinational read, write on the rising edge. The write
  // request is captured just before the edge so a reset asserted mid-cycle
  // suppresses it.
  logic [31:0] mem [32];
  assign dm_rd = mem[dm_address];
  initial begin
    logic       pend_we;
    logic [4:0] pend_a;
    logic [31:0] pend_d;
    for (int i = 0; i < 32; i++) mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      #4;
      pend_we = dm_we;
      pend_a  = dm_address;
      pend_d  = dm_wd;
      @(posedge clk);
      if (pend_we) mem[pend_a] <= pend_d;
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          done_cnt;
    logic        has_we;
    int          we_cnt;
    logic [4:0]  we_idx;
    logic [31:0] we_data;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          we_total = 0;
  int          exp_we_total = 0;
  logic [7:0]  rb [128];
  logic [31:0] exp_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic bad_req(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_ERR_EN
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] word_of(input int i);
    return {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]};
  endfunction

  // Monitor: compares writes and completions against the queued expectations.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (dm_we) begin
        we_total++;
        if (q.size() == 0 || !q[0].has_we) fail("unexpected_dm_we");
        else begin
          chk("we_cycle", 32'(cnt), 32'(q[0].we_cnt));
          chk("we_index", {27'b0, dm_address}, {27'b0, q[0].we_idx});
          chk("we_data", dm_wd, q[0].we_data);
        end
      end
      if (done) begin
        if (q.size() == 0) fail("spurious_done");
        else begin
          e = q.pop_front();
          chk("done_cycle", 32'(cnt), 32'(e.done_cnt));
          chk("err", {31'b0, err}, {31'b0, e.err});
          chk("rdata", rdata, e.rdata);
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) fail("drain_timeout");
  endtask

  // Issue one request at a negedge; the model is updated and the expected
  // response queued. With poke set, a store request is waved while busy.
  task automatic issue(input logic st, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input bit poke);
    bit          ok;
    exp_t        e;
    logic        b;
    int          nb, acc;
    logic [6:0]  sb;
    logic [31:0] val;
    wait_ready(ok);
    if (!ok) begin
      fail("ready_timeout");
      return;
    end
    req = 1'b1; store = st; size = sz; uns = u; addr = a; wdata = wd;
    acc = cnt + 1;
    b  = bad_req(sz, a);
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    sb = (nb == 1) ? a[6:0] : (nb == 2) ? {a[6:1], 1'b0} : {a[6:2], 2'b00};
    e.err = b; e.has_we = 1'b0; e.we_cnt = -1; e.we_idx = a[6:2]; e.we_data = '0;
    if (!b) begin
      if (!st) begin
        val = '0;
        for (int k = 0; k < nb; k++) val = val | (32'(rb[7'(sb + k)]) << (8 * k));
        if (!u && nb == 1) val = {{24{val[7]}}, val[7:0]};
        if (!u && nb == 2) val = {{16{val[15]}}, val[15:0]};
        exp_rdata = val;
      end else begin
        for (int k = 0; k < nb; k++) rb[7'(sb + k)] = 8'(wd >> (8 * k));
        e.has_we  = 1'b1;
        e.we_cnt  = acc + ((nb < 4) ? 1 : 0);
        e.we_data = word_of(int'(a[6:2]));
        exp_we_total++;
      end
    end
    e.rdata    = exp_rdata;
    e.done_cnt = acc + (b ? 0 : ((st && nb < 4) ? 2 : 1));
    q.push_back(e);
    @(negedge clk);
    if (poke) begin
      req = 1'b1; store = 1'b1; size = 2'b10; addr = 32'h0; wdata = $urandom;
      @(negedge clk);
    end
    req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  sv [4];
    logic [31:0] a;
    logic [1:0]  sz;
    for (int i = 0; i < 32; i++) begin
      a = init_word(i);
      for (int k = 0; k < 4; k++) rb[4*i+k] = a[8*k +: 8];
    end

    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_dm_we", {31'b0, dm_we}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_dm_address", {27'b0, dm_address}, 32'd0);
    chk("rst_dm_wd", dm_wd, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word round trip, byte RMW, sign/zero extension.
    issue(1'b1, 2'b10, 1'b0, 32'h14, 32'h11223344, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0);
    issue(1'b1, 2'b00, 1'b0, 32'h15, 32'h000000AA, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0);
    issue(1'b1, 2'b10, 1'b0, 32'h14, 32'h8000FF7F, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 32'h16, 32'h0, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 32'h15, 32'h0, 1'b0);
    issue(1'b0, 2'b00, 1'b1, 32'h15, 32'h0, 1'b0);
    issue(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 1'b0);
    issue(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 1'b0);
    // Misaligned word load, then a busy-time poke and an address wrap.
    issue(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b0);
    issue(1'b1, 2'b10, 1'b0, 32'h94, 32'hCAFEF00D, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b1);
    issue(1'b1, 2'b01, 1'b0, 32'h1A, 32'h0000BEEF, 1'b1);
    drain();

    // Reset during MERGE of a byte store: the write must not happen.
    for (int k = 0; k < 4; k++) sv[k] = rb[32 + k];
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h00000055, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_dm_we", {31'b0, dm_we}, 32'd0);
    q.delete();
    for (int k = 0; k < 4; k++) rb[32 + k] = sv[k];
    exp_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, ready}, 32'd1);
    chk("post_rst_done", {31'b0, done}, 32'd0);
    chk("post_rst_rdata", rdata, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = (sz == 2'b00) ? a[1:0] : (sz == 2'b01) ? {a[1], 1'b0} : 2'b00;
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
            ($urandom_range(0, 3) == 0));
    end
    drain();

    for (int i = 0; i < 32; i++) chk($sformatf("mem_word_%0d", i), mem[i], word_of(i));
    chk("write_count", 32'(we_total), 32'(exp_we_total));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
